// File: rtl/fetch_pc_generator_if.sv
// Fetch PC generator bus: groups the BTB/predictor inputs, the backend
// redirect and the fetch-side outputs of the PC generator.
//
//  btbHit        lane i BTB tag match for fetchPC + i*INSN_BYTE_WIDTH
//  btbOut        lane i predicted target, lane i at [i*PC_WIDTH +: PC_WIDTH]
//  readIsCondBr  lane i BTB entry is a conditional branch
//  predTaken     lane i direction-predictor taken bit
//  stall         downstream cannot accept the current group
//  recoverValid  backend redirect request
//  recoverPC     redirect target
//  predNextPC    address presented to BTB/I-cache this cycle
//  fetchPC       PC of the group whose BTB data is valid now
//  fetchValid    group at fetchPC may be delivered
//  laneValid     lanes up to and including the first predicted-taken lane
//  brPredTaken   one-hot predicted-taken lane, or 0
//
// master: the surrounding fetch unit (drives BTB/predictor/backend inputs)
// slave : the PC generator itself
interface fetch_pc_generator_if #(
    parameter int FETCH_WIDTH = 2,
    parameter int PC_WIDTH    = 32
);
    logic [FETCH_WIDTH-1:0]          btbHit;
    logic [FETCH_WIDTH*PC_WIDTH-1:0] btbOut;
    logic [FETCH_WIDTH-1:0]          readIsCondBr;
    logic [FETCH_WIDTH-1:0]          predTaken;
    logic                            stall;
    logic                            recoverValid;
    logic [PC_WIDTH-1:0]             recoverPC;
    logic [PC_WIDTH-1:0]             predNextPC;
    logic [PC_WIDTH-1:0]             fetchPC;
    logic                            fetchValid;
    logic [FETCH_WIDTH-1:0]          laneValid;
    logic [FETCH_WIDTH-1:0]          brPredTaken;

    modport master (
        output btbHit, btbOut, readIsCondBr, predTaken, stall, recoverValid, recoverPC,
        input  predNextPC, fetchPC, fetchValid, laneValid, brPredTaken
    );

    modport slave (
        input  btbHit, btbOut, readIsCondBr, predTaken, stall, recoverValid, recoverPC,
        output predNextPC, fetchPC, fetchValid, laneValid, brPredTaken
    );
endinterface

// File: rtl/fetch_pc_generator.sv
// Fetch PC generator: owns the fetch PC register and computes predNextPC,
// the address sent to the BTB read port and I-cache each cycle. BTB data for
// an address arrives one cycle after it is issued, so the lane decode below
// always refers to the group at fetchPC.
//
// Ports:
//  clk  clock
//  rst  synchronous active-high reset; starts the BTB/predictor reset sweep
//  bus  fetch_pc_generator_if.slave (see interface header for signal list)
//
// State table:
//  state    | meaning
//  ST_INIT  | BTB/predictor reset sweep running, fetch held at RESET_PC
//  ST_PRIME | first read of RESET_PC issued, BTB data not yet valid
//  ST_RUN   | normal fetch, groups delivered
module fetch_pc_generator #(
    parameter int                   FETCH_WIDTH     = 2,
    parameter int                   PC_WIDTH        = 32,
    parameter int                   INSN_BYTE_WIDTH = 4,
    parameter logic [PC_WIDTH-1:0]  RESET_PC        = 32'h0000_1000,
    parameter int                   INIT_CYCLES     = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_pc_generator_if.slave   bus
);

    localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(INIT_CYCLES - 1);
    localparam logic [PC_WIDTH-1:0] GROUP_INC = PC_WIDTH'(FETCH_WIDTH * INSN_BYTE_WIDTH);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     initCnt;
    logic [PC_WIDTH-1:0]  fetchPCq;
    logic [PC_WIDTH-1:0]  nextPC;

    logic [FETCH_WIDTH-1:0] laneTaken;
    logic [FETCH_WIDTH-1:0] firstTakenOH;
    logic [FETCH_WIDTH-1:0] upToFirst;
    logic                   anyTaken;
    logic [PC_WIDTH-1:0]    takenTarget;
    logic                   running;
    logic                   groupValid;

    assign laneTaken = bus.btbHit & (~bus.readIsCondBr | bus.predTaken);

    // Lowest taken lane wins; upToFirst covers lanes 0..f, or every lane
    // when nothing is taken.
    always_comb begin
        logic pastFirst;
        anyTaken     = 1'b0;
        firstTakenOH = '0;
        upToFirst    = '0;
        takenTarget  = '0;
        pastFirst    = 1'b0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            upToFirst[i] = !pastFirst;
            if (laneTaken[i] && !pastFirst) begin
                pastFirst       = 1'b1;
                anyTaken        = 1'b1;
                firstTakenOH[i] = 1'b1;
                takenTarget     = bus.btbOut[i*PC_WIDTH +: PC_WIDTH];
            end
        end
    end

    assign running    = !rst && (state == ST_RUN);
    // The group at fetchPC is wrong-path when the backend redirects.
    assign groupValid = running && !bus.recoverValid;

    always_comb begin
        nextPC = RESET_PC;
        if (!rst) begin
            unique case (state)
                ST_PRIME: nextPC = fetchPCq;
                ST_RUN: begin
                    if (bus.recoverValid) begin
                        nextPC = bus.recoverPC;
                    end else if (bus.stall) begin
                        // Re-read the same address so BTB data stays aligned.
                        nextPC = fetchPCq;
                    end else if (anyTaken) begin
                        nextPC = takenTarget;
                    end else begin
                        nextPC = fetchPCq + GROUP_INC;
                    end
                end
                default: nextPC = RESET_PC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            initCnt  <= '0;
            fetchPCq <= RESET_PC;
        end else begin
            fetchPCq <= nextPC;
            unique case (state)
                ST_INIT: begin
                    if (initCnt == CNT_LAST) begin
                        state <= ST_PRIME;
                    end else begin
                        initCnt <= initCnt + 1'b1;
                    end
                end
                ST_PRIME: state <= ST_RUN;
                ST_RUN:   state <= ST_RUN;
                default:  state <= ST_INIT;
            endcase
        end
    end

    assign bus.predNextPC  = nextPC;
    assign bus.fetchPC     = rst ? RESET_PC : fetchPCq;
    assign bus.fetchValid  = groupValid;
    assign bus.laneValid   = groupValid ? upToFirst : '0;
    assign bus.brPredTaken = groupValid ? firstTakenOH : '0;

endmodule

// File: tb/tb_fetch_pc_generator.sv
module tb_fetch_pc_generator;

    localparam int          FW       = 2;
    localparam int          PW       = 32;
    localparam int          INIT_CYC = 1024;
    localparam logic [31:0] RST_PC   = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_pc_generator_if #(.FETCH_WIDTH(FW), .PC_WIDTH(PW)) bus ();

    fetch_pc_generator #(
        .FETCH_WIDTH(FW), .PC_WIDTH(PW), .INSN_BYTE_WIDTH(4),
        .RESET_PC(RST_PC), .INIT_CYCLES(INIT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  hit, cond, pt;
        logic [31:0] out0, out1;
        logic        stall, recV;
        logic [31:0] recPC;
    } stim_t;

    typedef struct {
        logic [31:0] pred, fpc;
        logic        fv;
        logic [1:0]  lv, bt;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    int nVec = 0;
    int nErr = 0;

    // Reference model: cycles since the reset edge, and the fetch PC.
    int          mSince   = 0;
    logic [31:0] mFetchPC = RST_PC;
    logic        lastFv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b0, hit: 2'b00, cond: 2'b00, pt: 2'b00, out0: 32'h0, out1: 32'h0,
              stall: 1'b0, recV: 1'b0, recPC: 32'h0};
        return s;
    endfunction

    function automatic stim_t rnd(input bit allowRec);
        stim_t s;
        s       = idle();
        s.hit   = 2'($urandom_range(0, 3));
        s.cond  = 2'($urandom_range(0, 3));
        s.pt    = 2'($urandom_range(0, 3));
        s.out0  = $urandom;
        s.out1  = $urandom;
        s.stall = ($urandom_range(0, 3) == 0);
        s.recV  = allowRec && ($urandom_range(0, 7) == 0);
        s.recPC = $urandom;
        return s;
    endfunction

    function automatic vec_t mk(input logic [1:0] hit, cond, pt, input logic [31:0] out0, out1,
                                input logic stall, recV, input logic [31:0] recPC,
                                input logic [31:0] ePred, eFpc, input logic eFv,
                                input logic [1:0] eLv, eBt);
        vec_t v;
        v.s = '{rst: 1'b0, hit: hit, cond: cond, pt: pt, out0: out0, out1: out1,
                stall: stall, recV: recV, recPC: recPC};
        v.e = '{pred: ePred, fpc: eFpc, fv: eFv, lv: eLv, bt: eBt};
        return v;
    endfunction

    function automatic exp_t modelEval(input stim_t s);
        exp_t e;
        int   f;
        bit   init, prime;
        f = -1;
        for (int i = 0; i < FW; i++)
            if (f < 0 && s.hit[i] && (!s.cond[i] || s.pt[i])) f = i;
        init  = s.rst || (mSince < INIT_CYC);
        prime = !s.rst && (mSince == INIT_CYC);
        e.fpc = s.rst ? RST_PC : mFetchPC;
        e.fv  = !init && !prime && !s.recV;
        if (init)            e.pred = RST_PC;
        else if (prime)      e.pred = mFetchPC;
        else if (s.recV)     e.pred = s.recPC;
        else if (s.stall)    e.pred = mFetchPC;
        else if (f >= 0)     e.pred = (f == 0) ? s.out0 : s.out1;
        else                 e.pred = mFetchPC + 32'd8;
        e.lv = !e.fv ? 2'b00 : (f < 0) ? 2'b11 : 2'((1 << (f + 1)) - 1);
        e.bt = (e.fv && f >= 0) ? 2'(1 << f) : 2'b00;
        return e;
    endfunction

    task automatic modelAdvance(input stim_t s, input exp_t e);
        if (s.rst) begin
            mSince   = 0;
            mFetchPC = RST_PC;
        end else begin
            if (mSince <= INIT_CYC) mSince++;
            mFetchPC = e.pred;
        end
    endtask

    task automatic drive(input stim_t s);
        rst              = s.rst;
        bus.btbHit       = s.hit;
        bus.readIsCondBr = s.cond;
        bus.predTaken    = s.pt;
        bus.btbOut       = {s.out1, s.out0};
        bus.stall        = s.stall;
        bus.recoverValid = s.recV;
        bus.recoverPC    = s.recPC;
    endtask

    task automatic checkOut(input string tag, input exp_t e);
        chk({tag, ".predNextPC"},  bus.predNextPC,          e.pred);
        chk({tag, ".fetchPC"},     bus.fetchPC,             e.fpc);
        chk({tag, ".fetchValid"},  {31'b0, bus.fetchValid}, {31'b0, e.fv});
        chk({tag, ".laneValid"},   {30'b0, bus.laneValid},  {30'b0, e.lv});
        chk({tag, ".brPredTaken"}, {30'b0, bus.brPredTaken}, {30'b0, e.bt});
    endtask

    task automatic runCycle(input stim_t s, input string tag);
        exp_t e;
        @(negedge clk);
        drive(s);
        #1;
        e = modelEval(s);
        checkOut(tag, e);
        lastFv = bus.fetchValid;
        @(posedge clk);
        modelAdvance(s, e);
    endtask

    // Counts cycles with fetchValid low after a reset, until it rises.
    task automatic measureSweep(input string tag, input bit randomInputs);
        int    cnt;
        stim_t s;
        cnt = 0;
        for (int k = 0; k < INIT_CYC + 50; k++) begin
            s = randomInputs ? rnd(1'b0) : idle();
            runCycle(s, tag);
            if (lastFv) break;
            cnt++;
        end
        chk({tag, ".sweepLen"}, cnt, INIT_CYC + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    vec_t tbl[20];

    initial begin
        stim_t s;
        exp_t  e;

        tbl[0]  = mk(2'b00, 2'b00, 2'b00, 32'h0,    32'h0,    0, 0, 32'h0,        32'h0000_1008, 32'h0000_1000, 1, 2'b11, 2'b00);
        tbl[1]  = mk(2'b00, 2'b00, 2'b00, 32'h0,    32'h0,    0, 0, 32'h0,        32'h0000_1010, 32'h0000_1008, 1, 2'b11, 2'b00);
        tbl[2]  = mk(2'b10, 2'b00, 2'b00, 32'h0,    32'h2000, 0, 0, 32'h0,        32'h0000_2000, 32'h0000_1010, 1, 2'b11, 2'b10);
        tbl[3]  = mk(2'b11, 2'b01, 2'b00, 32'h5555, 32'h3000, 0, 0, 32'h0,        32'h0000_3000, 32'h0000_2000, 1, 2'b11, 2'b10);
        tbl[4]  = mk(2'b01, 2'b00, 2'b00, 32'h4444, 32'h9999, 0, 0, 32'h0,        32'h0000_4444, 32'h0000_3000, 1, 2'b01, 2'b01);
        tbl[5]  = mk(2'b11, 2'b11, 2'b01, 32'h0100, 32'h0200, 0, 0, 32'h0,        32'h0000_0100, 32'h0000_4444, 1, 2'b01, 2'b01);
        tbl[6]  = mk(2'b11, 2'b11, 2'b10, 32'h0300, 32'h0600, 0, 0, 32'h0,        32'h0000_0600, 32'h0000_0100, 1, 2'b11, 2'b10);
        tbl[7]  = mk(2'b00, 2'b00, 2'b00, 32'h0,    32'h0,    0, 0, 32'h0,        32'h0000_0608, 32'h0000_0600, 1, 2'b11, 2'b00);
        tbl[8]  = mk(2'b01, 2'b00, 2'b00, 32'h7777, 32'h0,    0, 1, 32'h1008,     32'h0000_1008, 32'h0000_0608, 0, 2'b00, 2'b00);
        tbl[9]  = mk(2'b10, 2'b00, 2'b00, 32'h0,    32'h7000, 1, 0, 32'h0,        32'h0000_1008, 32'h0000_1008, 1, 2'b11, 2'b10);
        tbl[10] = mk(2'b00, 2'b00, 2'b00, 32'h0,    32'h0,    1, 0, 32'h0,        32'h0000_1008, 32'h0000_1008, 1, 2'b11, 2'b00);
        tbl[11] = mk(2'b00, 2'b00, 2'b00, 32'h0,    32'h0,    1, 0, 32'h0,        32'h0000_1008, 32'h0000_1008, 1, 2'b11, 2'b00);
        tbl[12] = mk(2'b00, 2'b00, 2'b00, 32'h0,    32'h0,    1, 1, 32'h4000,     32'h0000_4000, 32'h0000_1008, 0, 2'b00, 2'b00);
        tbl[13] = mk(2'b00, 2'b00, 2'b00, 32'h0,    32'h0,    0, 0, 32'h0,        32'h0000_4008, 32'h0000_4000, 1, 2'b11, 2'b00);
        tbl[14] = mk(2'b00, 2'b00, 2'b00, 32'h0,    32'h0,    0, 1, 32'h5000,     32'h0000_5000, 32'h0000_4008, 0, 2'b00, 2'b00);
        tbl[15] = mk(2'b00, 2'b00, 2'b00, 32'h0,    32'h0,    0, 1, 32'h6000,     32'h0000_6000, 32'h0000_5000, 0, 2'b00, 2'b00);
        tbl[16] = mk(2'b00, 2'b00, 2'b00, 32'h0,    32'h0,    0, 0, 32'h0,        32'h0000_6008, 32'h0000_6000, 1, 2'b11, 2'b00);
        tbl[17] = mk(2'b00, 2'b00, 2'b00, 32'h0,    32'h0,    0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'h0000_6008, 0, 2'b00, 2'b00);
        tbl[18] = mk(2'b00, 2'b00, 2'b00, 32'h0,    32'h0,    0, 0, 32'h0,        32'h0000_0000, 32'hFFFF_FFF8, 1, 2'b11, 2'b00);
        tbl[19] = mk(2'b00, 2'b00, 2'b00, 32'h0,    32'h0,    0, 0, 32'h0,        32'h0000_0008, 32'h0000_0000, 1, 2'b11, 2'b00);

        drive(idle());
        rst = 1'b1;

        // Reset then idle: fetch held off for the sweep plus the prime cycle.
        s     = idle();
        s.rst = 1'b1;
        runCycle(s, "reset");
        measureSweep("init1", 1'b0);

        // Directed table, starting from the first RUN cycle. measureSweep
        // consumed that cycle, so reset once more to begin RUN at RESET_PC.
        runCycle(s, "reset2");
        for (int k = 0; k < INIT_CYC + 1; k++) runCycle(idle(), "init2");
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(tbl[k].s);
            #1;
            checkOut($sformatf("tbl%0d", k), tbl[k].e);
            e = modelEval(tbl[k].s);
            @(posedge clk);
            modelAdvance(tbl[k].s, e);
        end

        // Reset mid-RUN at fetchPC 0x2000; later reset mid-sweep restarts it.
        s       = idle();
        s.recV  = 1'b1;
        s.recPC = 32'h0000_2000;
        runCycle(s, "toRst");
        @(negedge clk);
        #1;
        chk("midRun.fetchPC", bus.fetchPC, 32'h0000_2000);
        s     = idle();
        s.rst = 1'b1;
        runCycle(s, "midRunRst");
        @(negedge clk);
        #1;
        chk("afterRst.fetchPC", bus.fetchPC, RST_PC);
        chk("afterRst.fetchValid", {31'b0, bus.fetchValid}, 32'h0);
        for (int k = 0; k < 300; k++) runCycle(rnd(1'b1), "initRnd");
        runCycle(s, "sweepRst");
        measureSweep("init3", 1'b1);

        // Randomized RUN traffic against the reference model.
        for (int k = 0; k < 2500; k++) begin
            s     = rnd(1'b1);
            s.rst = ($urandom_range(0, 999) == 0);
            runCycle(s, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
